display_scan_scheduler: RTL

//  Time-multiplexes one shared BCD-to-7-segment decoder across NUM_DIGITS digits of a common-anode display.

---
 rtl/display_pkg.sv | 20 ++
 rtl/scan_slot_timer.sv | 33 +++
 rtl/display_scan_scheduler.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | display_pkg                                                                |
// | Shared types and constants for the multiplexed 7-segment scan scheduler.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHOW  = 2'd2,
    ST_GUARD = 2'd3
  } scan_state_t;

  localparam int unsigned SETUP_CYCLES = 2;
  localparam logic [3:0]  BCD_MAX      = 4'd9;

endpackage
`default_nettype wire

// File: rtl/scan_slot_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | scan_slot_timer                                                            |
// | Loadable down-counter; tc_o marks the last cycle of the loaded phase.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module scan_slot_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;

  // Loading N-1 yields a phase of exactly N cycles, the last one flagged by tc_o.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign tc_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/display_scan_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | display_scan_scheduler                                                     |
// | Time-multiplexes one BCD-to-7-segment decoder across NUM_DIGITS anodes.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module display_scan_scheduler
  import display_pkg::*;
#(
  parameter int unsigned  NUM_DIGITS   = 4,
  parameter int unsigned  REFRESH_DIV  = 50000,
  parameter int unsigned  BLANK_CYCLES = 8,
  localparam int unsigned SEL_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic                    enable,
  input  logic                    blank_lz,
  output logic [3:0]              numero,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic [SEL_W-1:0]        digit_sel,
  output logic                    frame_done
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV + BLANK_CYCLES + 2);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

  scan_state_t             state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [3:0]              numero_q, numero_d;
  logic [NUM_DIGITS-1:0]   en_n_q, en_n_d;
  logic                    fd_q, fd_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic                    blz_q, blz_d;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    zero_up;
  logic                    tmr_load, tmr_tc;
  logic [CNT_W-1:0]        tmr_val;
  logic                    frame_start, next_slot;

  scan_slot_timer #(.WIDTH(CNT_W)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  // Walk from the most significant digit down so zero_up means "this and all above are 0".
  always_comb begin
    zero_up    = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_up       = zero_up && (active_q[4*i +: 4] == 4'd0);
      blank_mask[i] = (active_q[4*i +: 4] > BCD_MAX) || (blz_q && (i != 0) && zero_up);
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    numero_d    = numero_q;
    en_n_d      = '1;
    fd_d        = 1'b0;
    pending_d   = load ? digits_in : pending_q;
    active_d    = active_q;
    blz_d       = blz_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    frame_start = 1'b0;
    next_slot   = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
      sel_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_SETUP;
          sel_d       = '0;
          frame_start = 1'b1;
          tmr_load    = 1'b1;
          tmr_val     = CNT_W'(SETUP_CYCLES - 1);
        end
        ST_SETUP: begin
          if (tmr_tc) begin
            state_d  = ST_SHOW;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(REFRESH_DIV - 1);
          end
        end
        ST_SHOW: begin
          if (tmr_tc) begin
            if (BLANK_CYCLES != 0) begin
              state_d  = ST_GUARD;
              tmr_load = 1'b1;
              tmr_val  = CNT_W'(BLANK_CYCLES - 1);
            end else begin
              next_slot = 1'b1;
            end
          end
        end
        ST_GUARD: begin
          if (tmr_tc) begin
            next_slot = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (next_slot) begin
        state_d  = ST_SETUP;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(SETUP_CYCLES - 1);
        if (sel_q == LAST_SEL) begin
          sel_d       = '0;
          fd_d        = 1'b1;
          frame_start = 1'b1;
        end else begin
          sel_d = sel_q + 1'b1;
        end
      end

      if (frame_start) begin
        active_d = load ? digits_in : pending_q;
        blz_d    = blank_lz;
      end

      // Decoder is fed from the next-state snapshot so it leads the anode by SETUP.
      numero_d = active_d[{sel_d, 2'b00} +: 4];
      if (state_d == ST_SHOW && !blank_mask[sel_d]) begin
        en_n_d[sel_d] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      numero_q  <= '0;
      en_n_q    <= '1;
      fd_q      <= 1'b0;
      pending_q <= '0;
      active_q  <= '0;
      blz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      numero_q  <= numero_d;
      en_n_q    <= en_n_d;
      fd_q      <= fd_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      blz_q     <= blz_d;
    end
  end

  assign numero     = numero_q;
  assign digit_en_n = en_n_q;
  assign digit_sel  = sel_q;
  assign frame_done = fd_q;

endmodule
`default_nettype wire
